eq_band_mixer: RTL
==================

// Module: eq_band_mixer
// PURPOSE
//  Consumes per-band 48-bit FIR results (left/right) on the filter bank's single
//  valid strobe. Weights each band by a host-programmed gain and sums the bands.
//  Rounds and saturates the sum to 24-bit stereo samples for the audio output path.
//  Time-multiplexed: one signed multiply per channel per clock, NUM_BANDS MAC cycles.
// PARAMETERS
//  NUM_BANDS  4   number of filter bands (band index width BW = $clog2(NUM_BANDS), min 1)
//  GAIN_W     16  gain width, signed Q2.14 (16'h4000 = unity)
//  OUT_SHIFT  29  arithmetic right shift from accumulator to Q1.23 output
// PORTS
//  clk           in   1        system clock; all state on posedge
//  reset         in   1        asynchronous, active-high reset
//  data_valid    in   1        1-clk strobe: l_band_in/r_band_in valid this cycle
//  l_band_in     in   48xNB    unpacked [NUM_BANDS-1:0] signed left band results
//  r_band_in     in   48xNB    unpacked [NUM_BANDS-1:0] signed right band results
//  gain_wr_en    in   1        write gain_wr_data into gain[gain_sel]
//  gain_sel      in   BW       gain register index; out-of-range index ignored
//  gain_wr_data  in   GAIN_W   signed gain value
//  mute          in   1        force outputs to 0 (valid still pulses)
//  overrun_clr   in   1        clears sticky overrun
//  l_data_out    out  24       signed left output sample
//  r_data_out    out  24       signed right output sample
//  out_valid     out  1        1-clk strobe, outputs valid
//  clip_l/clip_r out  1        1-clk, coincident with out_valid: channel saturated
//  busy          out  1        high from capture through output cycle
//  overrun       out  1        sticky: data_valid arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, accumulators 0, every gain[i] = 16'h4000.
//  FSM: IDLE -> MAC -> ROUND -> OUT -> IDLE.
//   IDLE: on data_valid (cycle T), snapshot all bands (L and R) and all gains, band_idx=0,
//         clear accumulators, busy=1 from T+1, go MAC.
//   MAC: acc += band[band_idx]*gain_snap[band_idx] (48x16 signed, full 64-bit product),
//        accumulator width 64+BW, no overflow possible. NUM_BANDS cycles (T+1..T+NB).
//        Last band -> ROUND.
//   ROUND: r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up).
//          Saturate to [-2^23, 2^23-1]; set clip flag when clamped.
//   OUT: register outputs; out_valid=1 at cycle T+NB+2 (T+6 default). busy drops next clk.
//  l_data_out/r_data_out hold until the next out_valid.
//  mute sampled in ROUND: outputs 0, clip flags 0.
//  Gain writes update gain[] immediately, including while busy. An in-flight sample
//   uses the gain snapshot taken at capture.
//  data_valid while busy (incl. OUT cycle): sample dropped, overrun<=1. Next IDLE accepts new.
//  overrun_clr coincident with a new overrun: set wins.
//  Reset asserted mid-operation: abort immediately, no out_valid, gains return to unity.
// TESTING
//  1. Unity gains, l_band_in[0]=48'h0000_4000_0000, others 0, valid @T
//     -> l_data_out=24'h008000, out_valid @T+6 only.
//  2. Unity gains, all 4 bands 48'h0000_4000_0000 both channels -> L=R=24'h020000, no clip.
//  3. gain0=16'h7FFF, band0=48'h7FFF_FFFF_FFFF -> 24'h7FFFFF, clip_l=1.
//     Band0=48'h8000_0000_0000 -> 24'h800000, clip_l=1.
//  4. Rounding, unity gain0: band0=48'h4000 -> 24'h000001.
//     Band0=-48'h4000 -> 24'h000000. Band0=48'h3FFF -> 0.
//  5. valid @T and @T+2 -> one out_valid @T+6, overrun=1.
//     overrun_clr -> 0. Write gain0=0 @T+1 -> current output 24'h008000, next sample 0.
//  6. reset pulse @T+3 mid-MAC -> no out_valid, busy=0, gain[*]=16'h4000.
//     Mute=1 -> out_valid pulses with L=R=0.

Source files
------------

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: weights per-band stereo FIR results by host-programmed gains,
// sums them with one multiply per channel per clock, then rounds and saturates
// the sum to signed 24-bit output samples.
//
//  state   | meaning
//  --------+--------------------------------------------------------
//  S_IDLE  | waiting for data_valid; capture bands and gain snapshot
//  S_MAC   | one band per clock into the accumulators
//  S_ROUND | round/saturate accumulators, apply mute, load outputs
//  S_OUT   | out_valid and clip flags presented for one clock
module eq_band_mixer #(
  parameter int NUM_BANDS = 4,
  parameter int GAIN_W    = 16,
  parameter int OUT_SHIFT = 29,
  localparam int BW       = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_valid,
  input  logic signed [47:0]       l_band_in [NUM_BANDS-1:0],
  input  logic signed [47:0]       r_band_in [NUM_BANDS-1:0],
  input  logic                     gain_wr_en,
  input  logic [BW-1:0]            gain_sel,
  input  logic [GAIN_W-1:0]        gain_wr_data,
  input  logic                     mute,
  input  logic                     overrun_clr,
  output logic [23:0]              l_data_out,
  output logic [23:0]              r_data_out,
  output logic                     out_valid,
  output logic                     clip_l,
  output logic                     clip_r,
  output logic                     busy,
  output logic                     overrun
);

  // Accumulator carries BW guard bits over the full 48+GAIN_W product, so the
  // sum of NUM_BANDS products can never wrap.
  localparam int AW = 48 + GAIN_W + BW;
  localparam logic signed [GAIN_W-1:0] UNITY   = GAIN_W'(1) << (GAIN_W - 2);
  localparam logic signed [AW-1:0]     RND     = AW'(1) << (OUT_SHIFT - 1);
  localparam logic signed [AW-1:0]     SAT_MAX = AW'(24'h7FFFFF);
  localparam logic signed [AW-1:0]     SAT_MIN = ~SAT_MAX;
  localparam logic [BW-1:0]            LAST    = BW'(NUM_BANDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic [BW-1:0]            idx_q;
  logic signed [47:0]       snap_l_q [NUM_BANDS-1:0];
  logic signed [47:0]       snap_r_q [NUM_BANDS-1:0];
  logic signed [GAIN_W-1:0] snap_g_q [NUM_BANDS-1:0];
  logic signed [GAIN_W-1:0] gain_q   [NUM_BANDS-1:0];
  logic signed [AW-1:0]     acc_l_q, acc_r_q, acc_l_d, acc_r_d;
  logic signed [AW-1:0]     rnd_l, rnd_r;
  logic [24:0]              sat_l, sat_r;
  logic [23:0]              data_l_q, data_r_q;
  logic                     clip_l_q, clip_r_q, overrun_q;

  function automatic logic [24:0] sat24(input logic signed [AW-1:0] v);
    if (v > SAT_MAX)      return {1'b1, 24'h7FFFFF};
    else if (v < SAT_MIN) return {1'b1, 24'h800000};
    else                  return {1'b0, v[23:0]};
  endfunction

  // MAC step for the current band and round-half-up of the finished sums
  always_comb begin
    acc_l_d = acc_l_q + AW'(snap_l_q[idx_q]) * AW'(snap_g_q[idx_q]);
    acc_r_d = acc_r_q + AW'(snap_r_q[idx_q]) * AW'(snap_g_q[idx_q]);
    rnd_l   = (acc_l_q + RND) >>> OUT_SHIFT;
    rnd_r   = (acc_r_q + RND) >>> OUT_SHIFT;
    sat_l   = sat24(rnd_l);
    sat_r   = sat24(rnd_r);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (data_valid) state_d = S_MAC;
      S_MAC:   if (idx_q == LAST) state_d = S_ROUND;
      S_ROUND: state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gain registers, capture snapshot, accumulation and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        gain_q[i]   <= UNITY;
        snap_g_q[i] <= '0;
        snap_l_q[i] <= '0;
        snap_r_q[i] <= '0;
      end
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      data_l_q  <= '0;
      data_r_q  <= '0;
      clip_l_q  <= 1'b0;
      clip_r_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // Host writes land immediately; the in-flight sample keeps its snapshot.
      if (gain_wr_en && (int'(gain_sel) < NUM_BANDS)) gain_q[gain_sel] <= gain_wr_data;

      // A new overrun beats a simultaneous clear.
      if (data_valid && (state_q != S_IDLE)) overrun_q <= 1'b1;
      else if (overrun_clr)                  overrun_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (data_valid) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
              snap_l_q[i] <= l_band_in[i];
              snap_r_q[i] <= r_band_in[i];
              snap_g_q[i] <= gain_q[i];
            end
            idx_q   <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
          end
        end
        S_MAC: begin
          acc_l_q <= acc_l_d;
          acc_r_q <= acc_r_d;
          idx_q   <= idx_q + BW'(1);
        end
        S_ROUND: begin
          data_l_q <= mute ? 24'h0 : sat_l[23:0];
          data_r_q <= mute ? 24'h0 : sat_r[23:0];
          clip_l_q <= mute ? 1'b0 : sat_l[24];
          clip_r_q <= mute ? 1'b0 : sat_r[24];
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = (state_q == S_OUT);
  assign clip_l     = out_valid & clip_l_q;
  assign clip_r     = out_valid & clip_r_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;
  assign l_data_out = data_l_q;
  assign r_data_out = data_r_q;

endmodule
